// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store initiator for a byte-addressed,
// little-endian 32-bit data memory. Handles one request at a time, does
// read-modify-write for byte/halfword stores, and extends load data.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side is ready only in IDLE. The response is held
// stable, with resp_valid high, until the edge where resp_ready is also high.
module mem_access_unit #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read_sig,
  output logic        mem_wrt_sig
);

  // Highest legal word-aligned base address.
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_n;

  // Latched request fields (only what later states still need).
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  offs_q;
  logic [15:0] wdata_q;

  // Next values of the registered outputs.
  logic        req_ready_n;
  logic        resp_valid_n;
  logic        resp_err_n;
  logic [31:0] resp_rdata_n;
  logic [31:0] mem_addr_n;
  logic [31:0] mem_wdata_n;
  logic        mem_read_n;
  logic        mem_wrt_n;

  logic        accept;
  logic        req_err;
  logic [31:0] req_base;

  assign req_base = {req_addr[31:2], 2'b00};
  assign accept   = (state == IDLE) && req_valid && req_ready;

  // Illegal size, misalignment, or a base beyond the last word. The base
  // compare is a full 32-bit compare, so wrapped addresses are errors too.
  assign req_err = (req_size == 2'd3) ||
                   ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                   (req_base > LAST_WORD);

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offs,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{offs, 3'b000} +: 8];
    h = word[{offs[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'd1:    r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store data onto the addressed lane of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offs,
                                              input logic [15:0] data);
    logic [31:0] m;
    m = word;
    if (size == 2'd0) m[{offs, 3'b000} +: 8] = data[7:0];
    else              m[{offs[1], 4'b0000} +: 16] = data;
    return m;
  endfunction

  // State, registered outputs and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'h0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_read_sig <= 1'b0;
      mem_wrt_sig  <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      offs_q       <= 2'd0;
      wdata_q      <= 16'h0;
    end else begin
      state        <= state_n;
      req_ready    <= req_ready_n;
      resp_valid   <= resp_valid_n;
      resp_err     <= resp_err_n;
      resp_rdata   <= resp_rdata_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      mem_read_sig <= mem_read_n;
      mem_wrt_sig  <= mem_wrt_n;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        offs_q  <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
      end
    end
  end

  // Next-state and next-output logic. Strobes default low, so each is high
  // for exactly the one cycle spent in RD or WR. The word read during RD is
  // captured at the end of that cycle directly into mem_wdata (merged, for
  // sub-word stores) or resp_rdata (extended, for loads).
  always_comb begin
    state_n      = state;
    req_ready_n  = req_ready;
    resp_valid_n = resp_valid;
    resp_err_n   = resp_err;
    resp_rdata_n = resp_rdata;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_read_n   = 1'b0;
    mem_wrt_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready_n = 1'b0;
          mem_addr_n  = req_base;
          if (req_err) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = ERR_DATA;
          end else if (req_we && (req_size == 2'd2)) begin
            state_n     = WR;
            mem_wrt_n   = 1'b1;
            mem_wdata_n = req_wdata;
          end else begin
            state_n    = RD;
            mem_read_n = 1'b1;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_n     = WR;
          mem_wrt_n   = 1'b1;
          mem_wdata_n = store_merge(mem_rdata, size_q, offs_q, wdata_q);
        end else begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = load_extend(mem_rdata, size_q, offs_q, sgn_q);
        end
      end
      WR: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        resp_err_n   = 1'b0;
        resp_rdata_n = 32'h0;
      end
      RESP: begin
        if (resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
          req_ready_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side initiator for the byte-addressed 32-bit data memory; the memory is the responder.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- Drives the memory port signals `mem_addr`, `mem_wdata`, `mem_read_sig` and `mem_wrt_sig`.
- Performs read-modify-write for byte and halfword stores, extracts and extends load data, and returns a single response per request.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; word-aligned base address must satisfy base <= MEM_BYTES-4.
- ERR_DATA, 32'hDEAD_BEEF, value placed on `resp_rdata` for error responses.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_signed  input  1  load sign-extends when 1, zero-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores; ERR_DATA on error.
- resp_err  output  1  misaligned, out-of-range, or illegal size.
- mem_addr  output  32  word-aligned address to memory (req_addr & ~3).
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  memory read word (little-endian: byte k = bits 8k+7:8k).
- mem_read_sig  output  1  read strobe.
- mem_wrt_sig  output  1  write enable; memory writes on the clk edge ending a cycle where it is high.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - req_ready = 1; resp_valid = 0; resp_err = 0; resp_rdata = 0.
  - mem_addr = 0; mem_wdata = 0; mem_read_sig = 0; mem_wrt_sig = 0.
  - A reset asserted during WR forces mem_wrt_sig low at once, so no write occurs at the following edge. Any in-flight request is discarded with no response.
- All port outputs are registered.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - On req_valid & req_ready, latch we/size/signed/addr/wdata and set mem_addr = addr & ~3.
  - Check for error: size == 3; halfword with addr[0] = 1; word with addr[1:0] != 0; or (addr & ~3) > MEM_BYTES-4.
  - Error: go to RESP with resp_err = 1 and resp_rdata = ERR_DATA. No memory strobe is issued.
  - Load, or store with size < 2: go to RD.
  - Word store: go to WR with mem_wdata = wdata.
- RD:
  - mem_read_sig = 1 for exactly one cycle.
  - At the end of the cycle, capture mem_rdata into an internal word register; mem_read_sig returns to 0 next cycle.
  - Load: select lane at addr[1:0] (byte) or addr[1] (halfword), extend per req_signed, then go to RESP.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the captured word at the addressed lane, drive mem_wdata with the merged word, then go to WR.
- WR: mem_wrt_sig = 1 for exactly one cycle, then go to RESP with resp_rdata = 0.
- RESP:
  - resp_valid = 1.
  - Hold resp_valid, resp_rdata and resp_err stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE, clear resp_valid, and set req_ready = 1 in the same edge.
  - No back-to-back overlap: throughput is one request per (latency + 1) cycles minimum.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- mem_read_sig and mem_wrt_sig are never high in the same cycle; both are 0 in IDLE and RESP.
- Addresses are fixed at 32 bits. Wrap-around beyond MEM_BYTES is an error, never a modulo access.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs at reset values immediately; req_ready = 1.
- Word store then load: store addr 8, data 32'h1122_3344 -> one mem_wrt_sig pulse with mem_addr 8, resp 2 cycles later. Then load word at 8 -> resp_rdata 32'h1122_3344, resp_err 0.
- Byte store read-modify-write:
  - Setup: word 12 = 32'hAABB_CCDD.
  - Store byte 8'h5A at addr 14 -> RD pulse, then WR pulse with mem_wdata 32'hAA5A_CCDD.
  - Load byte signed at 15 -> 32'hFFFF_FFAA; unsigned -> 32'h0000_00AA.
  - Load halfword signed at 12 -> 32'hFFFF_CCDD.
- Errors:
  - Word load at addr 6 -> resp_err 1, ERR_DATA, no strobes.
  - Word load at addr 1024 -> resp_err 1.
  - Halfword load at addr 3 -> resp_err 1.
  - req_size 3 -> resp_err 1.
- Response backpressure: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready 0, a new req_valid is ignored. Raise resp_ready -> accepted, and the next request is accepted on the following cycle.
- Reset during WR of a word store to addr 16 (old value 32'h0) -> no write; a later load of 16 returns 32'h0 and no stale response appears.
